// File: rtl/bs_result_collector.sv
// Collects single-cycle Black-Scholes engine results into per-engine slots and
// round-robin drains them through a first-word-fall-through FIFO onto one stream.
module bs_result_collector #(
  parameter int BSMODS     = 20,
  parameter int RESWIDTH   = 64,
  parameter int IDWIDTH    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [BSMODS-1:0]                    BS_DONE,
  input  logic [BSMODS-1:0][RESWIDTH-1:0]      ap_return,
  input  logic [BSMODS-1:0][IDWIDTH-1:0]       opt_id,
  output logic [BSMODS-1:0]                    slot_busy,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [RESWIDTH-1:0]                  res_data,
  output logic [IDWIDTH-1:0]                   res_id,
  output logic [$clog2(BSMODS)-1:0]            res_engine,
  output logic [BSMODS-1:0]                    ovf_err,
  input  logic                                 ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level
);

  localparam int IDXW = $clog2(BSMODS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int SW   = IDXW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0]   MODS_C   = SW'(BSMODS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BSMODS - 1);
  localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [BSMODS-1:0]                slot_valid_r;
  logic [BSMODS-1:0][RESWIDTH-1:0]  slot_res_r;
  logic [BSMODS-1:0][IDWIDTH-1:0]   slot_id_r;
  logic [IDXW-1:0]                  rr_ptr_r;
  logic [BSMODS-1:0]                ovf_err_r;

  logic [RESWIDTH-1:0]              fifo_res_r [FIFO_DEPTH];
  logic [IDWIDTH-1:0]               fifo_id_r  [FIFO_DEPTH];
  logic [IDXW-1:0]                  fifo_eng_r [FIFO_DEPTH];
  logic [PW-1:0]                    wr_ptr_r;
  logic [PW-1:0]                    rd_ptr_r;
  logic [CW-1:0]                    count_r;
  logic                             res_valid_r;
  logic [RESWIDTH-1:0]              res_data_r;
  logic [IDWIDTH-1:0]               res_id_r;
  logic [IDXW-1:0]                  res_engine_r;

  logic                             grant_s;
  logic [IDXW-1:0]                  gnt_idx_s;
  logic [SW-1:0]                    cand_s;
  logic [IDXW-1:0]                  cand_idx_s;
  logic [BSMODS-1:0]                capture_s;
  logic [BSMODS-1:0]                clear_s;
  logic [BSMODS-1:0]                ovf_set_s;
  logic                             push_s;
  logic                             pop_s;
  logic [PW-1:0]                    wr_ptr_next_s;
  logic [PW-1:0]                    rd_ptr_next_s;
  logic [CW-1:0]                    count_next_s;
  logic [RESWIDTH-1:0]              head_res_s;
  logic [IDWIDTH-1:0]               head_id_s;
  logic [IDXW-1:0]                  head_eng_s;

  // Round-robin search from rr_ptr_r over busy slots; registered state only.
  always_comb begin
    grant_s    = 1'b0;
    gnt_idx_s  = {IDXW{1'b0}};
    cand_s     = {SW{1'b0}};
    cand_idx_s = {IDXW{1'b0}};
    if (count_r < DEPTH_C) begin
      for (int off = 0; off < BSMODS; off++) begin
        cand_s = {1'b0, rr_ptr_r} + SW'(off);
        if (cand_s >= MODS_C) begin
          cand_s = cand_s - MODS_C;
        end else begin
          cand_s = cand_s;
        end
        cand_idx_s = cand_s[IDXW-1:0];
        if (!grant_s && slot_valid_r[cand_idx_s]) begin
          grant_s   = 1'b1;
          gnt_idx_s = cand_idx_s;
        end else begin
          grant_s   = grant_s;
        end
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  // Per-slot capture / release / overflow decisions.
  always_comb begin
    capture_s = {BSMODS{1'b0}};
    clear_s   = {BSMODS{1'b0}};
    ovf_set_s = {BSMODS{1'b0}};
    for (int i = 0; i < BSMODS; i++) begin
      capture_s[i] = BS_DONE[i] &&
                     (!slot_valid_r[i] || (grant_s && (gnt_idx_s == IDXW'(i))));
      clear_s[i]   = !BS_DONE[i] && grant_s && (gnt_idx_s == IDXW'(i));
      ovf_set_s[i] = BS_DONE[i] && slot_valid_r[i] &&
                     !(grant_s && (gnt_idx_s == IDXW'(i)));
    end
  end

  // FIFO pointer/count next-state and the head word seen after this edge.
  always_comb begin
    push_s = grant_s;
    pop_s  = res_valid_r && res_ready;
    if (push_s) begin
      wr_ptr_next_s = (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
    // The word being pushed becomes the head when it lands at the next read slot.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_res_s = slot_res_r[gnt_idx_s];
      head_id_s  = slot_id_r[gnt_idx_s];
      head_eng_s = gnt_idx_s;
    end else begin
      head_res_s = fifo_res_r[rd_ptr_next_s];
      head_id_s  = fifo_id_r[rd_ptr_next_s];
      head_eng_s = fifo_eng_r[rd_ptr_next_s];
    end
  end

  // Holding slots, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_r <= {BSMODS{1'b0}};
      slot_res_r   <= {(BSMODS*RESWIDTH){1'b0}};
      slot_id_r    <= {(BSMODS*IDWIDTH){1'b0}};
      rr_ptr_r     <= {IDXW{1'b0}};
      ovf_err_r    <= {BSMODS{1'b0}};
    end else begin
      for (int i = 0; i < BSMODS; i++) begin
        if (capture_s[i]) begin
          slot_valid_r[i] <= 1'b1;
          slot_res_r[i]   <= ap_return[i];
          slot_id_r[i]    <= opt_id[i];
        end else if (clear_s[i]) begin
          slot_valid_r[i] <= 1'b0;
        end else begin
          slot_valid_r[i] <= slot_valid_r[i];
        end
      end
      if (grant_s) begin
        rr_ptr_r <= (gnt_idx_s == LAST_IDX) ? {IDXW{1'b0}} : gnt_idx_s + {{(IDXW-1){1'b0}}, 1'b1};
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      // A new overflow in the clearing cycle survives the clear.
      if (ovf_clr) begin
        ovf_err_r <= ovf_set_s;
      end else begin
        ovf_err_r <= ovf_err_r | ovf_set_s;
      end
    end
  end

  // Output FIFO storage, pointers and registered stream outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_res_r[j] <= {RESWIDTH{1'b0}};
        fifo_id_r[j]  <= {IDWIDTH{1'b0}};
        fifo_eng_r[j] <= {IDXW{1'b0}};
      end
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      res_valid_r  <= 1'b0;
      res_data_r   <= {RESWIDTH{1'b0}};
      res_id_r     <= {IDWIDTH{1'b0}};
      res_engine_r <= {IDXW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_res_r[wr_ptr_r] <= slot_res_r[gnt_idx_s];
        fifo_id_r[wr_ptr_r]  <= slot_id_r[gnt_idx_s];
        fifo_eng_r[wr_ptr_r] <= gnt_idx_s;
      end
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      res_valid_r  <= (count_next_s != {CW{1'b0}});
      res_data_r   <= head_res_s;
      res_id_r     <= head_id_s;
      res_engine_r <= head_eng_s;
    end
  end

  assign slot_busy  = slot_valid_r;
  assign ovf_err    = ovf_err_r;
  assign fifo_level = count_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_id     = res_id_r;
  assign res_engine = res_engine_r;

endmodule

// File: tb/tb_bs_result_collector.sv
// Directed scenario bench for bs_result_collector with hand-computed expectations.
module tb_bs_result_collector;

  localparam int N  = 20;
  localparam int RW = 64;
  localparam int IW = 32;
  localparam int EW = 5;
  localparam int LW = 4;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [N-1:0]            BS_DONE;
  logic [N-1:0][RW-1:0]    ap_return;
  logic [N-1:0][IW-1:0]    opt_id;
  logic [N-1:0]            slot_busy;
  logic                    res_valid;
  logic                    res_ready;
  logic [RW-1:0]           res_data;
  logic [IW-1:0]           res_id;
  logic [EW-1:0]           res_engine;
  logic [N-1:0]            ovf_err;
  logic                    ovf_clr;
  logic [LW-1:0]           fifo_level;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] got_eng[$];
  logic [RW-1:0] got_data[$];
  logic [IW-1:0] got_id[$];

  bs_result_collector dut (
    .clock(clock), .reset(reset), .BS_DONE(BS_DONE), .ap_return(ap_return),
    .opt_id(opt_id), .slot_busy(slot_busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .res_engine(res_engine), .ovf_err(ovf_err), .ovf_clr(ovf_clr),
    .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    BS_DONE   = '0;
    ap_return = '0;
    opt_id    = '0;
    ovf_clr   = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic load(input int i, input logic [RW-1:0] v, input logic [IW-1:0] id);
    BS_DONE[i]   = 1'b1;
    ap_return[i] = v;
    opt_id[i]    = id;
  endtask

  // Records every word offered while res_ready is high, up to n words.
  task automatic collect(input int n, input int budget);
    got_eng.delete();
    got_data.delete();
    got_id.delete();
    for (int c = 0; c < budget && got_eng.size() < n; c++) begin
      if (res_valid) begin
        got_eng.push_back(res_engine);
        got_data.push_back(res_data);
        got_id.push_back(res_id);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    clear_inputs;
    res_ready = 1'b0;
    reset = 1'b0;
    #2;
    vectors++;
    if ({slot_busy, res_valid, ovf_err, fifo_level} !== '0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%h valid=%b ovf=%h level=%0d, want all 0", slot_busy, res_valid, ovf_err, fifo_level);
    end
    vectors++;
    if ({res_data, res_id, res_engine} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: data=%h id=%h eng=%0d, want 0", res_data, res_id, res_engine);
    end
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_single;
    res_ready = 1'b1;
    load(3, 64'h4059_0000_0000_0000, 32'd77);
    tick;
    clear_inputs;
    vectors++;
    if (slot_busy !== 20'h0_0008 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_t1: busy=%h valid=%b, want 00008 0", slot_busy, res_valid);
    end
    tick;
    vectors++;
    if (slot_busy !== 20'h0 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_t2_flags: busy=%h valid=%b, want 0 1", slot_busy, res_valid);
    end
    vectors++;
    if (res_data !== 64'h4059_0000_0000_0000 || res_id !== 32'd77 || res_engine !== 5'd3) begin
      miscompares++;
      $display("FAIL single_t2_data: data=%h id=%0d eng=%0d, want 4059000000000000 77 3", res_data, res_id, res_engine);
    end
    tick;
    vectors++;
    if (res_valid !== 1'b0 || fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL single_t3: valid=%b level=%0d, want 0 0", res_valid, fifo_level);
    end
  endtask

  task automatic test_all_engines;
    do_reset;
    res_ready = 1'b1;
    for (int burst = 0; burst < 2; burst++) begin
      for (int i = 0; i < N; i++) load(i, 64'h1000 + 64'(burst * 256 + i), 32'(200 + i));
      tick;
      clear_inputs;
      vectors++;
      if (slot_busy !== 20'hF_FFFF || res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL all_busy b%0d: busy=%h valid=%b, want fffff 0", burst, slot_busy, res_valid);
      end
      tick;
      // Consecutive cycles: collect() records one word per cycle while valid stays high.
      collect(N, N);
      vectors++;
      if (got_eng.size() !== N) begin
        miscompares++;
        $display("FAIL all_count b%0d: got %0d in %0d cycles, want %0d", burst, got_eng.size(), N, N);
      end
      for (int i = 0; i < got_eng.size(); i++) begin
        vectors++;
        if (got_eng[i] !== EW'(i) || got_data[i] !== 64'h1000 + 64'(burst * 256 + i) || got_id[i] !== 32'(200 + i)) begin
          miscompares++;
          $display("FAIL all_order b%0d[%0d]: eng=%0d data=%h id=%0d, want %0d %h %0d", burst, i, got_eng[i], got_data[i], got_id[i], i, 64'h1000 + 64'(burst * 256 + i), 200 + i);
        end
      end
    end
  endtask

  task automatic test_rr_pointer;
    do_reset;
    res_ready = 1'b1;
    load(5, 64'h55, 32'd5);
    load(6, 64'h66, 32'd6);
    tick;
    clear_inputs;
    collect(2, 10);
    vectors++;
    if (got_eng.size() !== 2 || got_eng[0] !== 5'd5 || got_eng[1] !== 5'd6) begin
      miscompares++;
      $display("FAIL rr_56: got %0d words first=%0d, want 2 words 5,6", got_eng.size(), got_eng.size() > 0 ? got_eng[0] : 5'd0);
    end
    load(3, 64'h33, 32'd3);
    load(9, 64'h99, 32'd9);
    tick;
    clear_inputs;
    collect(2, 10);
    vectors++;
    if (got_eng.size() !== 2 || got_eng[0] !== 5'd9 || got_eng[1] !== 5'd3 || got_data[0] !== 64'h99) begin
      miscompares++;
      $display("FAIL rr_from7: got %0d words first=%0d, want 2 words 9,3", got_eng.size(), got_eng.size() > 0 ? got_eng[0] : 5'd0);
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    res_ready = 1'b0;
    for (int i = 0; i < 12; i++) load(i, 64'h3000 + 64'(i), 32'(300 + i));
    tick;
    clear_inputs;
    repeat (10) tick;
    vectors++;
    if (fifo_level !== 4'd8 || slot_busy !== 20'h0_0F00 || ovf_err !== 20'h0) begin
      miscompares++;
      $display("FAIL bp_full: level=%0d busy=%h ovf=%h, want 8 00f00 0", fifo_level, slot_busy, ovf_err);
    end
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 64'h3000 || res_engine !== 5'd0) begin
      miscompares++;
      $display("FAIL bp_head: valid=%b data=%h eng=%0d, want 1 3000 0", res_valid, res_data, res_engine);
    end
    repeat (3) tick;
    vectors++;
    if (res_data !== 64'h3000 || res_id !== 32'd300) begin
      miscompares++;
      $display("FAIL bp_stable: data=%h id=%0d, want 3000 300", res_data, res_id);
    end
    res_ready = 1'b1;
    collect(12, 40);
    vectors++;
    if (got_eng.size() !== 12) begin
      miscompares++;
      $display("FAIL bp_count: got %0d, want 12", got_eng.size());
    end
    for (int i = 0; i < got_eng.size(); i++) begin
      vectors++;
      if (got_eng[i] !== EW'(i) || got_data[i] !== 64'h3000 + 64'(i)) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: eng=%0d data=%h, want %0d %h", i, got_eng[i], got_data[i], i, 64'h3000 + 64'(i));
      end
    end
    vectors++;
    if (fifo_level !== 4'd0 || slot_busy !== 20'h0 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: level=%0d busy=%h valid=%b, want 0 0 0", fifo_level, slot_busy, res_valid);
    end
  endtask

  task automatic fill_high_engines;
    res_ready = 1'b0;
    for (int i = 10; i < 18; i++) load(i, 64'h4000 + 64'(i), 32'(400 + i));
    tick;
    clear_inputs;
    repeat (10) tick;
  endtask

  task automatic test_overflow;
    do_reset;
    fill_high_engines;
    vectors++;
    if (fifo_level !== 4'd8) begin
      miscompares++;
      $display("FAIL ovf_fill: level=%0d, want 8", fifo_level);
    end
    load(2, 64'hAAAA, 32'd2002);
    tick;
    load(2, 64'hBBBB, 32'd2003);
    tick;
    clear_inputs;
    vectors++;
    if (ovf_err !== 20'h0_0004 || slot_busy !== 20'h0_0004) begin
      miscompares++;
      $display("FAIL ovf_set: ovf=%h busy=%h, want 00004 00004", ovf_err, slot_busy);
    end
    res_ready = 1'b1;
    collect(9, 40);
    vectors++;
    if (got_eng.size() !== 9) begin
      miscompares++;
      $display("FAIL ovf_count: got %0d, want 9", got_eng.size());
    end else if (got_eng[8] !== 5'd2 || got_data[8] !== 64'hAAAA || got_id[8] !== 32'd2002 || got_eng[0] !== 5'd10) begin
      miscompares++;
      $display("FAIL ovf_kept: eng=%0d data=%h id=%0d first=%0d, want 2 aaaa 2002 10", got_eng[8], got_data[8], got_id[8], got_eng[0]);
    end
    vectors++;
    if (ovf_err !== 20'h0_0004 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky: ovf=%h valid=%b, want 00004 0", ovf_err, res_valid);
    end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    vectors++;
    if (ovf_err !== 20'h0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%h, want 0", ovf_err);
    end
    fill_high_engines;
    load(2, 64'hAAAA, 32'd2002);
    tick;
    load(2, 64'hBBBB, 32'd2003);
    ovf_clr = 1'b1;
    tick;
    clear_inputs;
    vectors++;
    if (ovf_err !== 20'h0_0004) begin
      miscompares++;
      $display("FAIL ovf_set_wins: ovf=%h, want 00004", ovf_err);
    end
  endtask

  task automatic test_recapture;
    do_reset;
    res_ready = 1'b1;
    load(0, 64'h5001, 32'd501);
    tick;
    ap_return[0] = 64'h5002;
    opt_id[0]    = 32'd502;
    vectors++;
    if (slot_busy[0] !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL recap_t1: busy0=%b valid=%b, want 1 0", slot_busy[0], res_valid);
    end
    tick;
    clear_inputs;
    vectors++;
    if (slot_busy[0] !== 1'b1 || res_valid !== 1'b1 || res_data !== 64'h5001 || res_id !== 32'd501) begin
      miscompares++;
      $display("FAIL recap_first: busy0=%b valid=%b data=%h id=%0d, want 1 1 5001 501", slot_busy[0], res_valid, res_data, res_id);
    end
    tick;
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 64'h5002 || res_id !== 32'd502 || slot_busy !== 20'h0 || ovf_err !== 20'h0) begin
      miscompares++;
      $display("FAIL recap_second: valid=%b data=%h id=%0d busy=%h ovf=%h, want 1 5002 502 0 0", res_valid, res_data, res_id, slot_busy, ovf_err);
    end
    tick;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL recap_done: valid=%b, want 0", res_valid);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(i, 64'h6000 + 64'(i), 32'(600 + i));
    tick;
    clear_inputs;
    repeat (5) tick;
    vectors++;
    if (fifo_level !== 4'd5 || slot_busy !== 20'h0_0020) begin
      miscompares++;
      $display("FAIL areset_pre: level=%0d busy=%h, want 5 00020", fifo_level, slot_busy);
    end
    res_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (res_valid !== 1'b0 || fifo_level !== 4'd0 || slot_busy !== 20'h0 || res_data !== 64'h0) begin
      miscompares++;
      $display("FAIL areset_now: valid=%b level=%0d busy=%h data=%h, want 0 0 0 0", res_valid, fifo_level, slot_busy, res_data);
    end
    tick;
    reset = 1'b1;
    load(7, 64'h7777, 32'd777);
    tick;
    clear_inputs;
    vectors++;
    if (res_valid !== 1'b0 || slot_busy !== 20'h0_0080) begin
      miscompares++;
      $display("FAIL areset_t1: valid=%b busy=%h, want 0 00080", res_valid, slot_busy);
    end
    tick;
    vectors++;
    if (res_valid !== 1'b1 || res_engine !== 5'd7 || res_data !== 64'h7777 || res_id !== 32'd777) begin
      miscompares++;
      $display("FAIL areset_t2: valid=%b eng=%0d data=%h id=%0d, want 1 7 7777 777", res_valid, res_engine, res_data, res_id);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_engines;
    test_rr_pointer;
    test_backpressure;
    test_overflow;
    test_recapture;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bs_result_collector.md
Name: bs_result_collector

Overview:
- Output-side counterpart of the per-engine packet registers that feed the Black-Scholes array.
- Captures each engine's single-cycle BS_DONE result (ap_return plus the option id it priced) into a per-engine holding slot.
- Round-robin arbitrates the slots into a FIFO and presents results as one valid/ready stream toward the host/egress packetizer.
- Also exports per-slot busy flags so the dispatcher does not restart an engine whose previous result is still held.

Parameters:
- BSMODS, 20, number of Black-Scholes engines.
- RESWIDTH, 64, width of ap_return.
- IDWIDTH, 32, width of opt_id.
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2).
- IDXW, $clog2(BSMODS), engine index width (derived, not overridden).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- BS_DONE  input  BSMODS  per-engine done pulse; ap_return/opt_id valid in that cycle only.
- ap_return  input  BSMODS x RESWIDTH  per-engine result.
- opt_id  input  BSMODS x IDWIDTH  per-engine option id, held by the packet register during compute.
- slot_busy  output  BSMODS  slot i holds an undrained result.
- res_valid  output  1  stream valid.
- res_ready  input  1  stream ready.
- res_data  output  RESWIDTH  result value.
- res_id  output  IDWIDTH  option id of the result.
- res_engine  output  IDXW  engine index that produced it.
- ovf_err  output  BSMODS  sticky per-engine overflow flags.
- ovf_clr  input  1  synchronous clear of all ovf_err bits.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset==0, async): slots empty, slot_busy=0, FIFO empty, fifo_level=0, res_valid=0, res_data/res_id/res_engine=0, ovf_err=0, RR pointer=0. Reset mid-operation discards all held and queued results.
- Capture:
  - BS_DONE[i]=1 latches {ap_return[i], opt_id[i]} into slot i and sets slot_busy[i] next cycle.
  - Done arriving while slot i is busy and not granted this cycle: new result dropped, old kept, ovf_err[i] set.
  - Done arriving in the same cycle slot i is granted: old value goes to FIFO, new value captured, slot stays busy, no overflow.
- Arbitration:
  - One grant per cycle, among busy slots, only when FIFO count < FIFO_DEPTH. Grant depends on registered state only; no combinational path from res_ready.
  - Search order starts at RR pointer; after granting k, pointer = (k+1) mod BSMODS (wraps BSMODS-1 -> 0). No grant leaves the pointer unchanged.
  - Grant pushes {result, id, k} into the FIFO and clears slot k, unless recaptured as above.
- FIFO:
  - Registered output, first-word-fall-through.
  - res_valid = (count!=0). Pop on res_valid & res_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Full blocks new grants; slots keep holding.
  - res_* stable while res_valid & !res_ready.
- Latency: done in cycle t -> slot_busy at t+1 -> grant at t+1 -> res_valid at t+2, for an empty FIFO, no contention and res_ready high. Throughput 1 result/cycle.
- ovf_clr clears ovf_err. If set and clear occur in the same cycle, set wins.
- Widths: fifo_level counts 0..FIFO_DEPTH; pointers are IDXW / log2(FIFO_DEPTH) bits with explicit modulo wrap.

Test Plan:
- Single result: BS_DONE[3] pulse, ap_return[3]=64'h4059_0000_0000_0000, opt_id[3]=32'd77, res_ready=1 -> res_valid at t+2 with res_data=64'h4059_0000_0000_0000, res_id=77, res_engine=3; slot_busy[3] high exactly one cycle.
- All engines done same cycle, res_ready=1 -> 20 results out on consecutive cycles in engine order 0..19. A following burst starts from pointer=0 again; after the grant sequence 5,6 the next search starts at 7.
- Backpressure: res_ready=0, 12 engines done -> fifo_level reaches 8, 4 slots stay busy, no ovf_err, res_data stable. Raise res_ready -> all 12 drained, none lost or duplicated.
- Overflow: with FIFO full, pulse BS_DONE[2] twice -> ovf_err[2]=1 and the first value delivered. Assert ovf_clr -> ovf_err=0. Repeat with a set coincident with ovf_clr -> ovf_err[2]=1.
- Recapture on grant: done on engine 0 in the exact cycle slot 0 is granted -> both values delivered in order, ovf_err[0]=0.
- Async reset asserted mid-drain with fifo_level=5 -> immediately res_valid=0, fifo_level=0, slot_busy=0. After release, a new single result appears with t+2 latency.
